// File: rtl/core_dispatch.sv
// core_dispatch
//   Round-robin scheduler that shares the input buffers of N_CORES SHA-512
//   cores between the data blocks coming out of engine block assembly. For
//   each block it grants a core with a free input slot in the requested
//   context. It then streams BLK_WORDS words into that core and commits the
//   block with a single core_set_input_ready pulse.
//
// Ports
//   CLK, reset_n          clock, asynchronous active-low reset
//   req/req_ctx/req_blk_op  block request from the engine, held until req_ack
//   req_ack               1-cycle pulse: core granted, request fields captured
//   din/din_valid/din_ready word stream; a word is taken when din_valid=1 in WRITE
//   core_ready            per core i, bit 4i+2*seq+ctx = input slot (seq,ctx) free
//   core_wr_en/core_wr_addr/core_din  write port to the granted core
//   core_blk_op/core_input_ctx/core_input_seq  held for the whole block
//   core_set_input_ready  1-cycle commit pulse to the granted core
//   grant_core            index of the granted core
//   err                   sticky protocol error
module core_dispatch #(
    parameter  int N_CORES   = 4,
    parameter  int MEM_WIDTH = 32,
    parameter  int BLK_WORDS = 16,
    parameter  int BLK_OP_W  = 4,
    localparam int GW        = $clog2(N_CORES)
) (
    input  logic                   CLK,
    input  logic                   reset_n,
    input  logic                   req,
    input  logic                   req_ctx,
    input  logic [BLK_OP_W-1:0]    req_blk_op,
    output logic                   req_ack,
    input  logic [MEM_WIDTH-1:0]   din,
    input  logic                   din_valid,
    output logic                   din_ready,
    input  logic [4*N_CORES-1:0]   core_ready,
    output logic [N_CORES-1:0]     core_wr_en,
    output logic [3:0]             core_wr_addr,
    output logic [MEM_WIDTH-1:0]   core_din,
    output logic [BLK_OP_W-1:0]    core_blk_op,
    output logic                   core_input_ctx,
    output logic                   core_input_seq,
    output logic                   core_set_input_ready,
    output logic [GW-1:0]          grant_core,
    output logic                   err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [3:0]         LAST_W = 4'(BLK_WORDS - 1);
    localparam logic [N_CORES-1:0] ONE_HOT0 = N_CORES'(1);

    state_t             state;
    logic [GW-1:0]      rr_ptr;
    logic [N_CORES-1:0] seq_ptr;
    logic [3:0]         w;
    logic               req_pend;   // req was high last cycle and not yet acknowledged
    logic               ctx_q;      // req_ctx seen last cycle

    logic [N_CORES-1:0] eligible;
    logic               found_hi, found_lo, sel_found;
    logic [GW-1:0]      sel_hi, sel_lo, sel;
    logic               grant_now;
    logic               err_cond;

    // Selection splits the cores into those at/after rr_ptr and those before
    // it, so the first match in the upper group wins over the lower group.
    // This gives the rotating priority without modulo index arithmetic.
    always_comb begin
        eligible = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        sel_hi   = '0;
        sel_lo   = '0;
        for (int unsigned i = 0; i < N_CORES; i++) begin
            logic [3:0] nib;
            nib         = core_ready[4*i +: 4];
            eligible[i] = nib[{seq_ptr[i], req_ctx}];
        end
        for (int unsigned i = 0; i < N_CORES; i++) begin
            if (eligible[i]) begin
                if (32'(rr_ptr) <= i) begin
                    if (!found_hi) begin
                        found_hi = 1'b1;
                        sel_hi   = GW'(i);
                    end
                end else if (!found_lo) begin
                    found_lo = 1'b1;
                    sel_lo   = GW'(i);
                end
            end
        end
        sel_found = found_hi | found_lo;
        sel       = found_hi ? sel_hi : sel_lo;
    end

    assign grant_now = (state == IDLE) && req && sel_found;
    assign err_cond  = (din_valid && (state != WRITE)) ||
                       (req && req_pend && (req_ctx != ctx_q));

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state                <= IDLE;
            rr_ptr               <= '0;
            seq_ptr              <= '0;
            w                    <= '0;
            req_pend             <= 1'b0;
            ctx_q                <= 1'b0;
            req_ack              <= 1'b0;
            din_ready            <= 1'b0;
            core_wr_en           <= '0;
            core_wr_addr         <= '0;
            core_din             <= '0;
            core_blk_op          <= '0;
            core_input_ctx       <= 1'b0;
            core_input_seq       <= 1'b0;
            core_set_input_ready <= 1'b0;
            grant_core           <= '0;
            err                  <= 1'b0;
        end else begin
            req_ack              <= 1'b0;
            core_wr_en           <= '0;
            core_set_input_ready <= 1'b0;
            // The ack cycle clears the pending flag so the engine may present
            // the next block with a different ctx right after the ack.
            req_pend             <= req && !grant_now && !req_ack;
            ctx_q                <= req_ctx;
            if (err_cond) begin
                err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (grant_now) begin
                        state          <= WRITE;
                        req_ack        <= 1'b1;
                        grant_core     <= sel;
                        core_input_ctx <= req_ctx;
                        core_input_seq <= seq_ptr[sel];
                        core_blk_op    <= req_blk_op;
                        din_ready      <= 1'b1;
                        w              <= '0;
                    end
                end
                WRITE: begin
                    if (din_valid) begin
                        core_wr_en   <= ONE_HOT0 << grant_core;
                        core_wr_addr <= w;
                        core_din     <= din;
                        w            <= w + 4'd1;
                        if (w == LAST_W) begin
                            din_ready <= 1'b0;
                            state     <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    core_set_input_ready <= 1'b1;
                    seq_ptr[grant_core]  <= ~seq_ptr[grant_core];
                    rr_ptr               <= (grant_core == GW'(N_CORES - 1)) ? '0
                                                                             : grant_core + GW'(1);
                    w                    <= '0;
                    state                <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
